// File: rtl/imem_fetch_requester.sv
// imem_fetch_requester
//   Core-side initiator for the shared instruction/data memory controller.
//   Captures one request per core while idle, presents all lanes packed on
//   the controller bus, and keeps re-issuing the lanes that have not been
//   granted yet. Each grant is followed by RAM_LAT latency cycles, after
//   which read data is captured from Dq and the served lanes get a
//   one-cycle core_ready pulse. A single bus-idle cycle (GAP) follows every
//   grant.
//
//   Optional build macro: FETCH_TIMEOUT_EN
//     adds output err and aborts a WAIT phase that sees no grant for
//     TIMEOUT cycles (pending lanes get core_ready, read data unchanged).
//
// Parameters
//   ncores   number of cores/lanes (only 3 supported; bus = 8*ncores bits)
//   RAM_LAT  cycles from grant to valid Dq (1..7)
//   TIMEOUT  WAIT cycles without grant before abort (1..255, macro only)
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   core_req/core_wr      per-core request and write flag (sampled in IDLE)
//   core_addr/core_wdata  per-lane address / write data (lane i at [8i+7:8i])
//   core_ready            one-cycle completion pulse per lane
//   core_rdata            per-lane read data, held until overwritten
//   busy                  high whenever not IDLE
//   rden/wren             per-lane read/write request to the controller
//   Address/Din           packed latched lane addresses / write data
//   acq                   per-lane grant from the controller
//   Dq                    packed read data from the controller
//   err                   (FETCH_TIMEOUT_EN only) one-cycle timeout pulse
module imem_fetch_requester #(
  parameter int ncores  = 3,
  parameter int RAM_LAT = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ncores-1:0]     core_req,
  input  logic [ncores-1:0]     core_wr,
  input  logic [8*ncores-1:0]   core_addr,
  input  logic [8*ncores-1:0]   core_wdata,
  output logic [ncores-1:0]     core_ready,
  output logic [8*ncores-1:0]   core_rdata,
  output logic                  busy,
  output logic [ncores-1:0]     rden,
  output logic [ncores-1:0]     wren,
  output logic [8*ncores-1:0]   Address,
  output logic [8*ncores-1:0]   Din,
  input  logic [ncores-1:0]     acq,
  input  logic [8*ncores-1:0]   Dq
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic                  err
`endif
);

  // One counter is shared by the LAT count and the WAIT timeout, so it is
  // sized for whichever of the two limits is larger.
  localparam int CNT_MAX = (TIMEOUT > RAM_LAT) ? TIMEOUT : RAM_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RAM_LAT - 1);
`ifdef FETCH_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_LAT,
    S_GAP
  } state_t;

  state_t              r_state;
  logic [ncores-1:0]   r_pend;
  logic [ncores-1:0]   r_wr;
  logic [ncores-1:0]   r_gnt;
  logic [8*ncores-1:0] r_addr;
  logic [8*ncores-1:0] r_din;
  logic [CNT_W-1:0]    r_cnt;

  logic [ncores-1:0]   w_hit;
  logic [8*ncores-1:0] w_req_mask;
  logic [8*ncores-1:0] w_cap_mask;
  logic                w_drive;

  always_comb begin
    w_req_mask = '0;
    w_cap_mask = '0;
    for (int unsigned i = 0; i < ncores; i++) begin
      w_req_mask[8*i +: 8] = {8{core_req[i]}};
      // only granted read lanes take their Dq slice
      w_cap_mask[8*i +: 8] = {8{r_gnt[i] & ~r_wr[i]}};
    end
  end

  assign w_hit   = acq & r_pend;
  assign w_drive = (r_state == S_WAIT) || (r_state == S_LAT);

  assign busy    = (r_state != S_IDLE);
  assign rden    = w_drive ? (r_pend & ~r_wr) : '0;
  assign wren    = w_drive ? (r_pend &  r_wr) : '0;
  assign Address = r_addr;
  assign Din     = r_din;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pend     <= '0;
      r_wr       <= '0;
      r_gnt      <= '0;
      r_addr     <= '0;
      r_din      <= '0;
      r_cnt      <= '0;
      core_ready <= '0;
      core_rdata <= '0;
`ifdef FETCH_TIMEOUT_EN
      err        <= 1'b0;
`endif
    end else begin
      core_ready <= '0;
`ifdef FETCH_TIMEOUT_EN
      err        <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (|core_req) begin
            r_pend  <= core_req;
            r_wr    <= core_wr;
            r_addr  <= core_addr  & w_req_mask;
            r_din   <= core_wdata & w_req_mask;
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // a grant wins over a timeout expiring in the same cycle
          if (|w_hit) begin
            r_gnt   <= w_hit;
            r_cnt   <= '0;
            r_state <= S_LAT;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (r_cnt == TO_LAST) begin
            core_ready <= r_pend;
            err        <= 1'b1;
            r_pend     <= '0;
            r_state    <= S_GAP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end
        S_LAT: begin
          if (r_cnt == LAT_LAST) begin
            core_rdata <= (core_rdata & ~w_cap_mask) | (Dq & w_cap_mask);
            core_ready <= r_gnt;
            r_pend     <= r_pend & ~r_gnt;
            r_state    <= S_GAP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_GAP: begin
          r_cnt   <= '0;
          r_state <= (|r_pend) ? S_WAIT : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
